// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT output reorder block.
//   data_width() - sample width from integer/fractional split
//   addr_width() - frame index width, log2(NFFT)
//   bitrev()     - reverse the low w bits of an index
//   W_* / R_*    - write and read FSM state encodings
package fft_pkg;

    localparam int BITREV_MAX_W = 16;

    localparam logic [0:0] W_WAIT_SOF = 1'b0;
    localparam logic [0:0] W_FILL     = 1'b1;

    localparam logic [0:0] R_IDLE     = 1'b0;
    localparam logic [0:0] R_BURST    = 1'b1;

    function automatic int data_width(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic int addr_width(input int nfft);
        return $clog2(nfft);
    endfunction

    // Bits at or above w are returned as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] x,
                                                       input int w);
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int b = 0; b < BITREV_MAX_W; b++) begin
            if (b < w) r[b] = x[w-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM backing the ping-pong frame buffer.
//   clk      in   write/read clock
//   i_we     in   write enable
//   i_waddr  in   write address {bank, index}
//   i_wdata  in   write data {real, imag}
//   i_re     in   read enable
//   i_raddr  in   read address {bank, index}
//   o_rdata  out  read data, valid the cycle after i_re (held otherwise)
// Contents are deliberately not reset.
module fft_reorder_ram #(
    parameter int DW = 36,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: converts the bit-reversed serial stream from the last
// SDF stage into natural-order frames using a ping-pong double buffer.
//   clk, rst            clock, asynchronous active-high reset
//   bypass              (FFT_REORDER_BYPASS_EN only) register inputs straight out
//   in_valid, in_sof    input sample strobe, first-sample-of-frame marker
//   in_r, in_i          bit-reversed-order complex sample
//   out_valid, out_sof  output strobe, high with natural bin 0
//   out_r, out_i        natural-order complex sample, held when out_valid=0
// Optional feature macro: FFT_REORDER_BYPASS_EN.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter  int INTEGER_SIZE = 6,
    parameter  int FRACT_SIZE   = 12,
    parameter  int NFFT         = 64,
    localparam int DATA_WIDTH   = data_width(INTEGER_SIZE, FRACT_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef FFT_REORDER_BYPASS_EN
    input  logic                         bypass,
`endif
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic signed [DATA_WIDTH-1:0] in_r,
    input  logic signed [DATA_WIDTH-1:0] in_i,
    output logic                         out_valid,
    output logic                         out_sof,
    output logic signed [DATA_WIDTH-1:0] out_r,
    output logic signed [DATA_WIDTH-1:0] out_i
);

    localparam int                ADDR_W = addr_width(NFFT);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NFFT - 1);

    logic w_byp;
`ifdef FFT_REORDER_BYPASS_EN
    assign w_byp = bypass;
`else
    assign w_byp = 1'b0;
`endif

    // write side
    logic [0:0]        r_wstate;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic              r_wb;
    // read side
    logic [0:0]        r_rstate;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic              r_rb;
    logic [1:0]        r_full;
    logic              r_rd_vld;
    logic              r_rd_sof;

    logic                    w_wr_fill;
    logic                    w_we;
    logic                    w_wr_last;
    logic [ADDR_W-1:0]       w_wr_idx;
    logic                    w_rd_en;
    logic                    w_rd_last;
    logic [1:0]              w_full_set;
    logic [1:0]              w_full_clr;
    logic [2*DATA_WIDTH-1:0] w_rd_data;

    assign w_wr_fill = (r_wstate == W_FILL);

    // A sof sample always lands at index 0, restarting the frame even mid-fill.
    assign w_we      = !w_byp && in_valid && (in_sof || (w_wr_fill && r_wr_cnt != '0));
    assign w_wr_idx  = in_sof ? '0 : ADDR_W'(bitrev(BITREV_MAX_W'(r_wr_cnt), ADDR_W));
    assign w_wr_last = !w_byp && in_valid && !in_sof && w_wr_fill && (r_wr_cnt == LAST);

    // Reading starts in the same cycle the bank is seen full, so the burst
    // begins without an IDLE->BURST bubble and bank hand-off is seamless.
    assign w_rd_en   = !w_byp && ((r_rstate == R_BURST) || r_full[r_rb]);
    assign w_rd_last = w_rd_en && (r_rd_cnt == LAST);

    assign w_full_set = w_wr_last ? (r_wb ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_clr = w_rd_last ? (r_rb ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_WAIT_SOF;
            r_wr_cnt <= '0;
            r_wb     <= 1'b0;
        end else if (w_byp) begin
            r_wstate <= W_WAIT_SOF;
            r_wr_cnt <= '0;
            r_wb     <= 1'b0;
        end else if (in_valid) begin
            if (in_sof) begin
                r_wstate <= W_FILL;
                r_wr_cnt <= ADDR_W'(1);
            end else if (w_wr_fill) begin
                if (r_wr_cnt == '0) begin
                    // a frame ended but no sof followed: drop and resync
                    r_wstate <= W_WAIT_SOF;
                end else if (r_wr_cnt == LAST) begin
                    r_wr_cnt <= '0;
                    r_wb     <= ~r_wb;
                end else begin
                    r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rd_cnt <= '0;
            r_rb     <= 1'b0;
            r_full   <= '0;
            r_rd_vld <= 1'b0;
            r_rd_sof <= 1'b0;
        end else if (w_byp) begin
            r_rstate <= R_IDLE;
            r_rd_cnt <= '0;
            r_rb     <= 1'b0;
            r_full   <= '0;
            r_rd_vld <= 1'b0;
            r_rd_sof <= 1'b0;
        end else begin
            r_full   <= (r_full | w_full_set) & ~w_full_clr;
            r_rd_vld <= w_rd_en;
            r_rd_sof <= w_rd_en && (r_rd_cnt == '0);
            if (w_rd_en) begin
                if (w_rd_last) begin
                    r_rd_cnt <= '0;
                    r_rb     <= ~r_rb;
                    r_rstate <= r_full[~r_rb] ? R_BURST : R_IDLE;
                end else begin
                    r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
                    r_rstate <= R_BURST;
                end
            end
        end
    end

    fft_reorder_ram #(
        .DW (2*DATA_WIDTH),
        .AW (ADDR_W+1)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr ({r_wb, w_wr_idx}),
        .i_wdata ({in_r, in_i}),
        .i_re    (w_rd_en),
        .i_raddr ({r_rb, r_rd_cnt}),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
        end else if (w_byp) begin
            out_valid <= in_valid;
            out_sof   <= in_valid && in_sof;
            out_r     <= in_r;
            out_i     <= in_i;
        end else begin
            out_valid <= r_rd_vld;
            out_sof   <= r_rd_sof;
            if (r_rd_vld) {out_r, out_i} <= w_rd_data;
        end
    end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer placed directly downstream of the last SDF FFT stage. It consumes the bit-reversed serial complex stream produced by the stage chain and re-emits each NFFT-point frame in natural frequency order. A ping-pong double buffer lets the block write one frame while reading the previous one, so continuous input produces continuous output. Data values pass through unmodified.

## Interface
- INTEGER_SIZE, 6, integer bits of each real/imag sample
- FRACT_SIZE, 12, fractional bits; DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE
- NFFT, 64, frame length; power of two, ≥4
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample present this cycle
- in_sof  in  1  qualifies the first sample of a frame (sampled only with in_valid)
- in_r, in_i  in  DATA_WIDTH signed  bit-reversed-order sample from last stage
- out_valid  out  1  output sample present
- out_sof  out  1  high with natural-order bin 0
- out_r, out_i  out  DATA_WIDTH signed  natural-order sample

## Operation
- Storage: 2 banks × NFFT complex words; write bank select wb, read bank = the other.
- Write FSM: W_WAIT_SOF → W_FILL.
  - W_WAIT_SOF: ignore samples until in_valid&in_sof; that sample is written at address bitrev(0)=0, wr_cnt←1, go W_FILL.
  - W_FILL: each in_valid writes at bitrev(wr_cnt) (ADDR_W=log2(NFFT) bits reversed), wr_cnt++. On the write with wr_cnt=NFFT-1: set full[wb], toggle wb, wr_cnt←0, stay W_FILL expecting in_sof next.
  - in_valid&in_sof while wr_cnt≠0: resync; partial frame discarded (full not set), sample written as index 0, wr_cnt←1.
  - in_valid without in_sof while wr_cnt=0 in W_FILL: go W_WAIT_SOF, sample dropped.
- Read FSM: R_IDLE → R_BURST.
  - R_IDLE: when full[rb] set, go R_BURST, rd_cnt←0.
  - R_BURST: one natural-order read per cycle, no gaps, independent of in_valid. After rd_cnt=NFFT-1: clear full[rb], toggle rb; if the other bank is already full, continue R_BURST seamlessly, else R_IDLE.
- Overrun cannot occur: a fill takes ≥NFFT cycles, a burst exactly NFFT. Full-set and burst-end in the same cycle → back-to-back frames with no gap.
- Output n of a frame equals input sample bitrev(n) of that frame.
- Reset: out_valid=0, out_sof=0, out_r=out_i=0, wr_cnt=rd_cnt=0, full flags 0, wb=0, rb=0, write FSM W_WAIT_SOF, read FSM R_IDLE. RAM contents not reset. Reset mid-frame discards both banks.

## Timing
- RAM write synchronous; RAM read synchronous (1 cycle) followed by output register.
- out_valid rises 2 cycles after the edge capturing a frame's last input sample; continuous input → first-in to first-out latency NFFT+1 cycles.
- out_sof coincides with out_valid on bin 0 only; out_r/out_i hold last value when out_valid=0.
- Throughput: one sample/cycle sustained.

## Configuration
- FFT_REORDER_BYPASS_EN defined: extra input port bypass (1 bit). While bypass=1, in_r/in_i/in_valid/in_sof are registered straight to outputs (latency 1), buffer FSMs held in reset state; toggling bypass takes effect next cycle and discards buffered frames.
- Undefined: no bypass port; reorder path only.

## Structure
- Shared package fft_pkg: DATA_WIDTH and ADDR_W derivation, bitrev function, write/read FSM state enums.
- One sub-module: fft_reorder_ram — simple dual-port RAM, 2·NFFT × 2·DATA_WIDTH, one write port, one synchronous read port, address = {bank, index}.

## Test plan
- Continuous frame, NFFT=64, sample k = (k, −k), in_sof on k=0 → out_valid at cycle 65, outputs n=0,1,2,3 = (0,0),(32,−32),(16,−16),(48,−48); out_sof only on n=0.
- Three back-to-back frames with offsets 0/100/200 → 192 consecutive out_valid cycles, no gap, frame order preserved.
- Input with in_valid low every other cycle → each output burst still 64 contiguous cycles, content correct, idle gaps between bursts.
- in_sof reasserted at k=20 → first 20 samples discarded; frame restarts, single correct output frame after 64 further samples.
- rst asserted mid-burst (n=30) → out_valid/out_sof/outputs 0 immediately; no residual output until a new full frame arrives.
- Samples before any in_sof, including full-scale (−2^17, 2^17−1) values → ignored; later frame with extremes reproduced bit-exact.
